sap_controller: RTL and testbench
=================================

# sap_controller

SAP-1 control sequencer: a six-state ring counter (T1–T6) plus an instruction decoder that drives the 12-bit control word for the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers. It sits beside the IR, takes the IR opcode nibble, and is the only block that asserts `Cp`/`Ep` to the program counter. It also owns the halt state.

## Interface
- No parameters.
- `CLK` input 1: system clock. The state register updates on the falling edge so the control word is stable before the datapath's rising edge.
- `nCLR` input 1: asynchronous, active-low reset (0 = clear).
- `opcode` input 4: IR[7:4]. Required stable from the rising edge ending T3 through T6.
- `con` output 12: control word. Bit order [11:0] = `Cp`, `Ep`, `nLm`, `nCE`, `nLi`, `nEi`, `nLa`, `Ea`, `Su`, `Eu`, `nLb`, `nLo`.
- `HLT` output 1: 1 = halted; used externally to gate the clock.
- `t_state` output 6: one-hot ring state, T1 = bit 0; all-zero in HALT.

## Operation
- States: T1..T6 (one-hot), HALT. T1→T2→…→T6→T1 on each falling edge.
- Idle word NOP = 12'h3E3 (all active-low signals 1, all active-high signals 0).
- Fetch, identical for every opcode:
  - T1 = 5E3 (Ep, nLm)
  - T2 = BE3 (Cp)
  - T3 = 263 (nCE, nLi)
- LDA 0000:
  - T4 = 1A3 (nLm, nEi)
  - T5 = 2C3 (nCE, nLa)
  - T6 = 3E3
- ADD 0001: T4 = 1A3, T5 = 2E1 (nCE, nLb), T6 = 3C7 (nLa, Eu).
- SUB 0010: T4 = 1A3, T5 = 2E1, T6 = 3CF (nLa, Su, Eu).
- OUT 1110: T4 = 3F2 (Ea, nLo), T5 = 3E3, T6 = 3E3.
- HLT 1111:
  - In T4, `HLT` = 1 combinationally and `con` = 3E3.
  - The next falling edge enters HALT: `con` = 3E3, `HLT` = 1, `t_state` = 0.
  - HALT is left only via `nCLR`.
- Undefined opcodes (0011–1101): T4–T6 = 3E3 (NOP).
- `con` and `HLT` are a pure decode of state and `opcode`. No glitch-sensitive outputs in T1–T3, because those words do not depend on `opcode`.

## Timing
- Reset: `nCLR` = 0 immediately forces T1 regardless of `CLK`. Outputs: `con` = 5E3, `HLT` = 0, `t_state` = 6'b000001.
- Reset release: the first falling edge after `nCLR` rises moves to T2.
- Reset mid-instruction or in HALT: abort immediately to T1. No partial-instruction completion.
- Instruction latency: 6 CLK cycles per instruction, measured falling edge to falling edge (without the Configuration macro).
- Ring wrap: T6 → T1 unconditionally, except HALT entry from T4.
- Control signals are valid for the whole state. Datapath registers capture on the rising edge mid-state.
- An `opcode` change during T1–T3 has no effect on `con`.

## Configuration
- `SAP_CTRL_EARLY_END_EN` defined:
  - LDA returns T5 → T1.
  - OUT and undefined opcodes return T4 → T1.
  - ADD and SUB are unchanged (T6 → T1).
  - HLT is unchanged.
  - LDA takes 5 cycles; OUT/NOP take 4.
- Not defined: every non-HLT instruction takes 6 states. T5/T6 idle words are emitted as listed under Operation.

## Test plan
- Reset: `nCLR` = 0 asserted mid-T5 of an ADD → `t_state` = 000001 and `con` = 5E3 immediately, before any clock edge. After release, the first falling edge gives `t_state` = 000010 and `con` = BE3.
- Fetch, `opcode` = 0000: `con` sequence T1..T6 = 5E3, BE3, 263, 1A3, 2C3, 3E3, then 5E3 again.
- ADD then SUB: T6 `con` = 3C7 for `opcode` 0001 and 3CF for `opcode` 0010. T5 = 2E1 for both.
- OUT, `opcode` = 1110: T4 `con` = 3F2. T5/T6 = 3E3 with the macro undefined. With `SAP_CTRL_EARLY_END_EN` defined, the next state after T4 is T1 (`con` = 5E3).
- HLT, `opcode` = 1111: `HLT` rises in T4. The following falling edge gives `t_state` = 0 and `con` = 3E3. Both stay frozen for 20 further cycles. Then `nCLR` pulse → T1, `HLT` = 0.
- Undefined `opcode` = 0101: T4–T6 `con` = 3E3, with no `Cp`/`Ep` assertion outside T1/T2.

Source files
------------

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: T1..T6 ring counter plus opcode decoder producing
// the 12-bit control word and the halt flag.
// Optional build macro SAP_CTRL_EARLY_END_EN: short instructions return to T1
// as soon as their last useful state is done (LDA after T5, OUT/NOP after T4).
module sap_controller (
  input  logic        CLK,
  input  logic        nCLR,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic        HLT,
  output logic [5:0]  t_state
);

  typedef enum logic [2:0] {
    ST_T1   = 3'd0,
    ST_T2   = 3'd1,
    ST_T3   = 3'd2,
    ST_T4   = 3'd3,
    ST_T5   = 3'd4,
    ST_T6   = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control words, bit order Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
  localparam logic [11:0] W_NOP   = 12'h3E3;
  localparam logic [11:0] W_FET1  = 12'h5E3;
  localparam logic [11:0] W_FET2  = 12'hBE3;
  localparam logic [11:0] W_FET3  = 12'h263;
  localparam logic [11:0] W_ADRIR = 12'h1A3;
  localparam logic [11:0] W_LDA5  = 12'h2C3;
  localparam logic [11:0] W_LDB   = 12'h2E1;
  localparam logic [11:0] W_ADD6  = 12'h3C7;
  localparam logic [11:0] W_SUB6  = 12'h3CF;
  localparam logic [11:0] W_OUT4  = 12'h3F2;

  state_t state, state_next;

  // State register: falling-edge update so the word settles before the datapath's rising edge
  always_ff @(negedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      state <= ST_T1;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: ring advance, HALT entry from T4, optional early return to T1
  always_comb begin
    state_next = ST_T1;
    unique case (state)
      ST_T1: state_next = ST_T2;
      ST_T2: state_next = ST_T3;
      ST_T3: state_next = ST_T4;
      ST_T4: begin
        if (opcode == OP_HLT) begin
          state_next = ST_HALT;
        end else begin
`ifdef SAP_CTRL_EARLY_END_EN
          if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
            state_next = ST_T5;
          end else begin
            state_next = ST_T1;
          end
`else
          state_next = ST_T5;
`endif
        end
      end
      ST_T5: begin
`ifdef SAP_CTRL_EARLY_END_EN
        state_next = (opcode == OP_LDA) ? ST_T1 : ST_T6;
`else
        state_next = ST_T6;
`endif
      end
      ST_T6:   state_next = ST_T1;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_T1;
    endcase
  end

  // Output decode: control word, halt flag and one-hot ring view from state and opcode
  always_comb begin
    con     = W_NOP;
    HLT     = 1'b0;
    t_state = '0;
    unique case (state)
      ST_T1: begin
        con        = W_FET1;
        t_state[0] = 1'b1;
      end
      ST_T2: begin
        con        = W_FET2;
        t_state[1] = 1'b1;
      end
      ST_T3: begin
        con        = W_FET3;
        t_state[2] = 1'b1;
      end
      ST_T4: begin
        t_state[3] = 1'b1;
        unique case (opcode)
          OP_LDA, OP_ADD, OP_SUB: con = W_ADRIR;
          OP_OUT:                 con = W_OUT4;
          OP_HLT:                 HLT = 1'b1;
          default:                con = W_NOP;
        endcase
      end
      ST_T5: begin
        t_state[4] = 1'b1;
        unique case (opcode)
          OP_LDA:         con = W_LDA5;
          OP_ADD, OP_SUB: con = W_LDB;
          default:        con = W_NOP;
        endcase
      end
      ST_T6: begin
        t_state[5] = 1'b1;
        unique case (opcode)
          OP_ADD:  con = W_ADD6;
          OP_SUB:  con = W_SUB6;
          default: con = W_NOP;
        endcase
      end
      ST_HALT: HLT = 1'b1;
      default: con = W_NOP;
    endcase
  end

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: directed instruction sequences and
// random instruction streams compared against a step-counter reference model.
module tb_sap_controller;

  logic        CLK;
  logic        nCLR;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic        HLT;
  logic [5:0]  t_state;

  int unsigned vectors;
  int unsigned miscompares;

  // Reference model: current T-step (1..6) and halted flag
  int m_step;
  bit m_halted;

  sap_controller dut (
    .CLK     (CLK),
    .nCLR    (nCLR),
    .opcode  (opcode),
    .con     (con),
    .HLT     (HLT),
    .t_state (t_state)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // Last step of an instruction before wrapping to T1
  function automatic int last_step(input logic [3:0] op);
`ifdef SAP_CTRL_EARLY_END_EN
    if (op == 4'b0000) return 5;
    if (op == 4'b0001 || op == 4'b0010) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  function automatic logic [11:0] exp_con(input int step, input bit halted, input logic [3:0] op);
    if (halted) return 12'h3E3;
    case (step)
      1: return 12'h5E3;
      2: return 12'hBE3;
      3: return 12'h263;
      4: begin
        if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) return 12'h1A3;
        if (op == 4'b1110) return 12'h3F2;
        return 12'h3E3;
      end
      5: begin
        if (op == 4'b0000) return 12'h2C3;
        if (op == 4'b0001 || op == 4'b0010) return 12'h2E1;
        return 12'h3E3;
      end
      6: begin
        if (op == 4'b0001) return 12'h3C7;
        if (op == 4'b0010) return 12'h3CF;
        return 12'h3E3;
      end
      default: return 12'hXXX;
    endcase
  endfunction

  function automatic logic [5:0] exp_t(input int step, input bit halted);
    logic [5:0] v;
    v = '0;
    if (!halted) v[step-1] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (step=%0d halted=%0d opcode=%b)",
             tag, obs, exp, m_step, m_halted, opcode);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".con"},     con,                 exp_con(m_step, m_halted, opcode));
    chk({tag, ".HLT"},     {11'b0, HLT},        {11'b0, (m_halted || (m_step == 4 && opcode == 4'b1111))});
    chk({tag, ".t_state"}, {6'b0, t_state},     {6'b0, exp_t(m_step, m_halted)});
  endtask

  // One falling edge: advance the model, then check outputs mid-low-phase
  task automatic cycle(input string tag);
    @(negedge CLK);
    if (!m_halted) begin
      if (m_step == 4 && opcode == 4'b1111) m_halted = 1'b1;
      else if (m_step >= last_step(opcode)) m_step = 1;
      else m_step++;
    end
    #2;
    check_all(tag);
  endtask

  // Reset pulse issued at negedge+2 time: assert on the rising edge, release before the next fall
  task automatic reset_pulse(input string tag);
    #3 nCLR = 1'b0;
    #1;
    m_step   = 1;
    m_halted = 1'b0;
    check_all(tag);
    #2 nCLR = 1'b1;
  endtask

  // Execute until back in T1 or halted; garbage opcode in T1/T2, real one from T3 on
  task automatic run(input string tag, input logic [3:0] op);
    for (int i = 0; i < 12; i++) begin
      opcode = (m_step < 3) ? 4'($urandom) : op;
      cycle(tag);
      if (m_halted || m_step == 1) break;
    end
    if (!m_halted && m_step != 1) begin
      miscompares++;
      $display("FAIL %s.ring observed=step%0d required=return_to_T1", tag, m_step);
    end
  endtask

  task automatic halt_hold(input string tag);
    for (int i = 0; i < 20; i++) cycle(tag);
    reset_pulse({tag, ".clr"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_step      = 1;
    m_halted    = 1'b0;
    nCLR        = 1'b0;
    opcode      = 4'b0000;

    #2 check_all("reset");
    @(negedge CLK);
    #2 check_all("reset_hold");
    nCLR = 1'b1;

    run("lda", 4'b0000);
    run("add", 4'b0001);
    run("sub", 4'b0010);
    run("out", 4'b1110);
    run("undef", 4'b0101);
    run("hlt", 4'b1111);
    halt_hold("halt");

    // Abort an ADD in T5
    opcode = 4'($urandom);
    cycle("abort.t2");
    cycle("abort.t3");
    opcode = 4'b0001;
    cycle("abort.t4");
    cycle("abort.t5");
    reset_pulse("abort.clr");
    run("after_abort", 4'b0001);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      case ($urandom_range(0, 6))
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b1110;
        4: op = 4'b1111;
        default: op = 4'($urandom);
      endcase
      run("rand", op);
      if (m_halted) begin
        for (int i = 0; i < 3; i++) cycle("rand.halt");
        reset_pulse("rand.clr");
      end else if ($urandom_range(0, 9) == 0) begin
        reset_pulse("rand.t1clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
